// File: rtl/image_addresser_pkg.sv
// rtl/image_addresser_pkg.sv - shared image addresser defaults and FSM state encoding
package image_addresser_pkg;

    localparam int kImageSize          = 128;
    localparam int kImageAddressLength = 15;
    localparam int kCacheDataLength    = 16;
    localparam int kFifoDepth          = 4;

    typedef enum logic [2:0] {
        ready_s,
        kick_s,
        work_s,
        drain_s,
        done_s
    } state_t;

endpackage

// File: rtl/image_addresser_fifo.sv
// rtl/image_addresser_fifo.sv - synchronous write buffer with registered count and full/empty flags
module image_addresser_fifo #(
    parameter int kWidth = 31,
    parameter int kDepth = image_addresser_pkg::kFifoDepth
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [kWidth-1:0] i_wdata,
    input  logic              i_pop,
    output logic [kWidth-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);
    localparam int kPtrW = (kDepth > 1) ? $clog2(kDepth) : 1;
    localparam logic [kPtrW:0] kFullCount = (kPtrW + 1)'(kDepth);

    logic [kWidth-1:0] r_mem [kDepth];
    logic [kPtrW-1:0]  r_wr_ptr;
    logic [kPtrW-1:0]  r_rd_ptr;
    logic [kPtrW:0]    r_count;
    logic              w_push;
    logic              w_pop;

    // Overflow and underflow are blocked here so the caller's handshake stays simple.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == kFullCount);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/image_addresser.sv
// rtl/image_addresser.sv - maps a raster pixel stream onto row- or column-major image RAM writes
module image_addresser #(
    parameter int kImageSize          = image_addresser_pkg::kImageSize,
    parameter int kImageAddressLength = image_addresser_pkg::kImageAddressLength,
    parameter int kCacheDataLength    = image_addresser_pkg::kCacheDataLength,
    parameter int kFifoDepth          = image_addresser_pkg::kFifoDepth
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ia_kick,
    input  logic                           ia_transpose,
    input  logic                           pv_valid,
    input  logic [kCacheDataLength-1:0]    pv_val,
    output logic                           pv_ready,
    output logic                           ir_kick,
    output logic                           ir_done,
    output logic [kImageAddressLength-1:0] ir_addr,
    output logic [kCacheDataLength-1:0]    ir_val,
    input  logic                           ir_enable,
    output logic                           ia_done
);
    import image_addresser_pkg::*;

    localparam int kAW = kImageAddressLength;
    localparam int kDW = kCacheDataLength;
    localparam logic [kAW-1:0] kSide = kAW'(kImageSize);
    localparam logic [kAW-1:0] kLast = kAW'(kImageSize - 1);

    state_t           r_state;
    logic             r_transpose;
    logic [kAW-1:0]   r_x;
    logic [kAW-1:0]   r_y;
    logic             r_ir_kick;
    logic             r_ir_done;
    logic             r_ia_done;
    logic [kAW-1:0]   r_ir_addr;
    logic [kDW-1:0]   r_ir_val;

    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [kAW-1:0]   w_addr;
    logic [kAW+kDW-1:0] w_head;

    assign pv_ready = (r_state == work_s) && !w_full;
    assign w_accept = pv_valid && pv_ready;
    assign w_pop    = !w_empty && ir_enable;
    assign w_addr   = r_transpose ? (r_x * kSide + r_y) : (r_y * kSide + r_x);

    assign ir_kick  = r_ir_kick;
    assign ir_done  = r_ir_done;
    assign ia_done  = r_ia_done;
    assign ir_addr  = r_ir_addr;
    assign ir_val   = r_ir_val;

    image_addresser_fifo #(
        .kWidth (kAW + kDW),
        .kDepth (kFifoDepth)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_wdata ({w_addr, pv_val}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ready_s;
            r_transpose <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_ir_kick   <= 1'b0;
            r_ir_done   <= 1'b0;
            r_ia_done   <= 1'b0;
            r_ir_addr   <= '1;
            r_ir_val    <= '0;
        end else begin
            r_ir_kick <= 1'b0;
            r_ir_done <= 1'b0;
            r_ia_done <= 1'b0;
            // Each popped entry is shown for exactly one cycle; idle cycles park the address at all-ones.
            r_ir_addr <= w_pop ? w_head[kAW+kDW-1 -: kAW] : '1;
            if (w_pop) begin
                r_ir_val <= w_head[kDW-1:0];
            end

            case (r_state)
                ready_s: begin
                    if (ia_kick) begin
                        r_transpose <= ia_transpose;
                        r_ir_kick   <= 1'b1;
                        r_state     <= kick_s;
                    end
                end
                kick_s: begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_state <= work_s;
                end
                work_s: begin
                    if (w_accept) begin
                        if (r_x == kLast) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                            if (r_y == kLast) begin
                                r_state <= drain_s;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                drain_s: begin
                    // Empty here means the final entry was popped last edge and is on ir_addr now.
                    if (w_empty) begin
                        r_ir_done <= 1'b1;
                        r_ia_done <= 1'b1;
                        r_state   <= done_s;
                    end
                end
                done_s: begin
                    r_state <= ready_s;
                end
                default: begin
                    r_state <= ready_s;
                end
            endcase
        end
    end

endmodule
